// File: rtl/ysyx_sq_ctrl.sv
// Committed-store queue: in-order FIFO of stores drained over a req/ack port.
// YSYX_SQ_BYPASS_EN: issue a push into an idle, empty queue in the same cycle.
module ysyx_sq_ctrl #(
  parameter int SQ_SIZE = 4,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cm_valid,
  input  logic            cm_store,
  input  logic [4:0]      cm_alu,
  input  logic [XLEN-1:0] cm_waddr,
  input  logic [XLEN-1:0] cm_wdata,
  output logic            cm_ready,
  output logic            st_req,
  output logic [XLEN-1:0] st_addr,
  output logic [XLEN-1:0] st_data,
  output logic [3:0]      st_wstrb,
  input  logic            st_ack,
  input  logic [XLEN-1:0] ld_addr,
  output logic            ld_hit,
  output logic            sq_empty
);

  localparam int PW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] addr_q [SQ_SIZE];
  logic [XLEN-1:0] data_q [SQ_SIZE];
  logic [1:0]      size_q [SQ_SIZE];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic last;
  logic [PW-1:0] off;

  logic [XLEN-1:0] h_addr;
  logic [XLEN-1:0] h_data;
  logic [1:0]      h_size;

  // size 3 is reserved and behaves as a word store
  function automatic logic [3:0] fmt_strb(
    input logic [1:0] sz,
    input logic [1:0] o
  );
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << o;
      2'd1:    s = 4'b0011 << {o[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] fmt_data(
    input logic [1:0]      sz,
    input logic [1:0]      o,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] d;
    case (sz)
      2'd0:    d = XLEN'(wd[7:0]) << {o, 3'b000};
      2'd1:    d = XLEN'(wd[15:0]) << {o[1], 4'b0000};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign full     = (cnt_q == CW'(SQ_SIZE));
  assign empty    = (cnt_q == '0);
  assign cm_ready = !full;
  assign push     = cm_valid & cm_store & cm_ready;
  assign sq_empty = empty & (state_q == S_IDLE);
  assign last     = (cnt_q == CW'(1)) & !push;

  assign h_addr = addr_q[head_q];
  assign h_data = data_q[head_q];
  assign h_size = size_q[head_q];

  always_comb begin
    state_d  = state_q;
    st_req   = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_wstrb = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
`ifdef YSYX_SQ_BYPASS_EN
        if (empty && push) begin
          bypass   = 1'b1;
          st_req   = 1'b1;
          st_addr  = {cm_waddr[XLEN-1:2], 2'b00};
          st_wstrb = fmt_strb(cm_alu[1:0], cm_waddr[1:0]);
          st_data  = fmt_data(cm_alu[1:0], cm_waddr[1:0], cm_wdata);
          pop      = st_ack;
          state_d  = st_ack ? S_IDLE : S_REQ;
        end else if (!empty) begin
          state_d = S_REQ;
        end
`else
        if (!empty) begin
          state_d = S_REQ;
        end
`endif
      end
      S_REQ: begin
        st_req   = 1'b1;
        st_addr  = {h_addr[XLEN-1:2], 2'b00};
        st_wstrb = fmt_strb(h_size, h_addr[1:0]);
        st_data  = fmt_data(h_size, h_addr[1:0], h_data);
        pop      = st_ack;
        if (st_ack && last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  // an entry is live when its distance from head is below the count
  always_comb begin
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      off = PW'(i) - head_q;
      if ((CW'(off) < cnt_q) &&
          (addr_q[i][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        ld_hit = 1'b1;
      end
    end
`ifdef YSYX_SQ_BYPASS_EN
    if (bypass && (cm_waddr[XLEN-1:2] == ld_addr[XLEN-1:2])) begin
      ld_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= cm_waddr;
      data_q[tail_q] <= cm_wdata;
      size_q[tail_q] <= cm_alu[1:0];
    end
  end

  logic unused;
  assign unused = ^{cm_alu[4:2], ld_addr[1:0], bypass};

endmodule
